// File: rtl/arcade_input_pkg.sv
// rtl/arcade_input_pkg.sv - scancode map, joystick bit indices and rotate modes for arcade_input_mapper
package arcade_input_pkg;

  localparam logic [3:0] JOY_R     = 4'd0;
  localparam logic [3:0] JOY_L     = 4'd1;
  localparam logic [3:0] JOY_D     = 4'd2;
  localparam logic [3:0] JOY_U     = 4'd3;
  localparam logic [3:0] JOY_BTN0  = 4'd4;
  localparam logic [3:0] JOY_START = 4'd8;
  localparam logic [3:0] JOY_COIN  = 4'd9;

  // Player 1 directions match on the 8-bit code only (extended or not)
  localparam logic [7:0] SC_P1_UP    = 8'h75;
  localparam logic [7:0] SC_P1_DOWN  = 8'h72;
  localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P1_RIGHT = 8'h74;

  localparam logic [8:0] SC_P1_B0    = 9'h014;
  localparam logic [8:0] SC_P1_B1    = 9'h011;
  localparam logic [8:0] SC_P1_B2    = 9'h029;
  localparam logic [8:0] SC_P1_B3    = 9'h012;
  localparam logic [8:0] SC_P2_UP    = 9'h02D;
  localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
  localparam logic [8:0] SC_P2_LEFT  = 9'h023;
  localparam logic [8:0] SC_P2_RIGHT = 9'h034;
  localparam logic [8:0] SC_P2_B0    = 9'h01C;
  localparam logic [8:0] SC_P2_B1    = 9'h01B;
  localparam logic [8:0] SC_P2_B2    = 9'h015;
  localparam logic [8:0] SC_P2_B3    = 9'h01D;
  localparam logic [8:0] SC_START1   = 9'h016;
  localparam logic [8:0] SC_F1       = 9'h005;
  localparam logic [8:0] SC_START2   = 9'h01E;
  localparam logic [8:0] SC_F2       = 9'h006;
  localparam logic [8:0] SC_COIN1    = 9'h02E;
  localparam logic [8:0] SC_COIN2    = 9'h036;
  localparam logic [8:0] SC_TEST     = 9'h02C;

  typedef enum logic [1:0] {ROT_0, ROT_CW, ROT_180, ROT_CCW} rot_e;

  typedef struct packed {
    logic       hit;
    logic       test;
    logic [1:0] player;
    logic [3:0] idx;
  } key_map_t;

  function automatic key_map_t key_lookup(input logic [8:0] code);
    key_map_t m;
    m     = '0;
    m.hit = 1'b1;
    case (code[7:0])
      SC_P1_UP:    m.idx = JOY_U;
      SC_P1_DOWN:  m.idx = JOY_D;
      SC_P1_LEFT:  m.idx = JOY_L;
      SC_P1_RIGHT: m.idx = JOY_R;
      default: begin
        case (code)
          SC_P1_B0:            m.idx = JOY_BTN0;
          SC_P1_B1:            m.idx = JOY_BTN0 + 4'd1;
          SC_P1_B2:            m.idx = JOY_BTN0 + 4'd2;
          SC_P1_B3:            m.idx = JOY_BTN0 + 4'd3;
          SC_P2_UP:            begin m.player = 2'd1; m.idx = JOY_U; end
          SC_P2_DOWN:          begin m.player = 2'd1; m.idx = JOY_D; end
          SC_P2_LEFT:          begin m.player = 2'd1; m.idx = JOY_L; end
          SC_P2_RIGHT:         begin m.player = 2'd1; m.idx = JOY_R; end
          SC_P2_B0:            begin m.player = 2'd1; m.idx = JOY_BTN0; end
          SC_P2_B1:            begin m.player = 2'd1; m.idx = JOY_BTN0 + 4'd1; end
          SC_P2_B2:            begin m.player = 2'd1; m.idx = JOY_BTN0 + 4'd2; end
          SC_P2_B3:            begin m.player = 2'd1; m.idx = JOY_BTN0 + 4'd3; end
          SC_START1, SC_F1:    m.idx = JOY_START;
          SC_START2, SC_F2:    begin m.player = 2'd1; m.idx = JOY_START; end
          SC_COIN1:            m.idx = JOY_COIN;
          SC_COIN2:            begin m.player = 2'd1; m.idx = JOY_COIN; end
          SC_TEST:             m.test = 1'b1;
          default:             m.hit = 1'b0;
        endcase
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// rtl/arcade_coin_pulse.sv - rising-edge triggered fixed-width coin pulse
module arcade_coin_pulse #(
  parameter int COIN_PULSE_CYCLES = 1200000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic trig,
  output logic pulse
);

  localparam int CW = $clog2(COIN_PULSE_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          trig_q;

  // Triggers during an active pulse are dropped, never extend it
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig;
      if (cnt != '0)
        cnt <= cnt - 1'b1;
      else if (trig && !trig_q)
        cnt <= CW'(COIN_PULSE_CYCLES);
    end
  end

  assign pulse = (cnt != '0);

endmodule

// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 key decode merged with joysticks, rotation, SOCD, coin pulses, autofire
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS       = 2,
  parameter int NUM_BUTTONS       = 4,
  parameter int COIN_PULSE_CYCLES = 1200000,
  parameter int AUTOFIRE_DIV      = 600000,
  parameter int SOCD_NEUTRAL      = 1
) (
  input  logic                             clk_sys,
  input  logic                             reset_n,
  input  logic [10:0]                      ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]        joystick,
  input  logic [1:0]                       rotate,
  input  logic                             coin_from_start,
  input  logic [NUM_PLAYERS-1:0]           autofire_en,
  output logic [4*NUM_PLAYERS-1:0]         dir,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn,
  output logic [NUM_PLAYERS-1:0]           start,
  output logic [NUM_PLAYERS-1:0]           coin,
  output logic                             test
);

  localparam int DIV_W = $clog2(AUTOFIRE_DIV + 1);

  logic                              old_tog;
  logic                              primed;
  logic                              key_event;
  logic                              test_key;
  logic [16*NUM_PLAYERS-1:0]         key_state;
  logic [16*NUM_PLAYERS-1:0]         raw;
  logic [4*NUM_PLAYERS-1:0]          dir_n;
  logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_n;
  logic [NUM_PLAYERS-1:0]            start_n;
  logic [NUM_PLAYERS-1:0]            coin_trig;
  logic [DIV_W-1:0]                  div_cnt;
  logic                              phase;
  logic                              unused_raw;
  key_map_t                          km;

  assign km        = key_lookup(ps2_key[8:0]);
  // The first clock after reset only captures the toggle, so a stale toggle is not a press
  assign key_event = primed && (ps2_key[10] != old_tog);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_tog   <= 1'b0;
      primed    <= 1'b0;
      test_key  <= 1'b0;
      key_state <= '0;
    end else begin
      old_tog <= ps2_key[10];
      primed  <= 1'b1;
      if (key_event && km.hit) begin
        if (km.test)
          test_key <= ps2_key[9];
        for (int p = 0; p < NUM_PLAYERS; p++)
          for (int b = 0; b < 10; b++)
            if (!km.test && km.player == 2'(p) && km.idx == 4'(b) &&
                (b < 4 + NUM_BUTTONS || b >= 8))
              key_state[p*16+b] <= ps2_key[9];
      end
    end
  end

  // d and result are {up, down, left, right}
  function automatic logic [3:0] steer(input logic [3:0] d, input rot_e rot);
    logic [3:0] o;
    case (rot)
      ROT_CW:  o = {d[1], d[0], d[2], d[3]};
      ROT_180: o = {d[2], d[3], d[0], d[1]};
      ROT_CCW: o = {d[0], d[1], d[3], d[2]};
      default: o = d;
    endcase
    if (SOCD_NEUTRAL != 0) begin
      if (o[3] && o[2]) o[3:2] = 2'b00;
      if (o[1] && o[0]) o[1:0] = 2'b00;
    end
    return o;
  endfunction

  always_comb begin
    raw       = '0;
    dir_n     = '0;
    btn_n     = '0;
    start_n   = '0;
    coin_trig = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      raw[p*16 +: 16] = key_state[p*16 +: 16] | joystick[p*16 +: 16];
      dir_n[p*4 +: 4] = steer(raw[p*16 +: 4], rot_e'(rotate));
      btn_n[p*NUM_BUTTONS +: NUM_BUTTONS] = raw[p*16+4 +: NUM_BUTTONS];
      if (autofire_en[p])
        btn_n[p*NUM_BUTTONS] = raw[p*16+4] & phase;
      start_n[p]   = raw[p*16+8];
      coin_trig[p] = raw[p*16+9] | (coin_from_start & raw[p*16+8]);
    end
  end

  assign unused_raw = ^raw;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir     <= '0;
      btn     <= '0;
      start   <= '0;
      test    <= 1'b0;
      div_cnt <= '0;
      phase   <= 1'b1;
    end else begin
      dir   <= dir_n;
      btn   <= btn_n;
      start <= start_n;
      test  <= test_key;
      if (div_cnt == DIV_W'(AUTOFIRE_DIV - 1)) begin
        div_cnt <= '0;
        phase   <= ~phase;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    arcade_coin_pulse #(
      .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)
    ) u_coin (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .trig   (coin_trig[p]),
      .pulse  (coin[p])
    );
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb/tb_arcade_input_mapper.sv - scoreboard bench for arcade_input_mapper
module tb_arcade_input_mapper;

  localparam int S_DIR = 0, S_BTN = 1, S_START = 2, S_COIN = 3, S_TEST = 4;

  logic        clk_sys;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [31:0] joystick;
  logic [1:0]  rotate;
  logic        coin_from_start;
  logic [1:0]  autofire_en;
  logic [7:0]  dir;
  logic [7:0]  btn;
  logic [1:0]  start;
  logic [1:0]  coin;
  logic        test;

  typedef struct packed {
    int          cyc;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic tog;

  arcade_input_mapper #(
    .NUM_PLAYERS(2), .NUM_BUTTONS(4), .COIN_PULSE_CYCLES(8),
    .AUTOFIRE_DIV(4), .SOCD_NEUTRAL(1)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
    .rotate(rotate), .coin_from_start(coin_from_start), .autofire_en(autofire_en),
    .dir(dir), .btn(btn), .start(start), .coin(coin), .test(test)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [15:0] get_sig(input int sel);
    case (sel)
      S_DIR:   return {8'h00, dir};
      S_BTN:   return {8'h00, btn};
      S_START: return {14'h0, start};
      S_COIN:  return {14'h0, coin};
      default: return {15'h0, test};
    endcase
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      S_DIR:   return "dir";
      S_BTN:   return "btn";
      S_START: return "start";
      S_COIN:  return "coin";
      default: return "test";
    endcase
  endfunction

  always @(negedge clk_sys) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (mon_e.cyc < cyc || get_sig(mon_e.sel) !== mon_e.val) begin
        errors++;
        $display("FAIL %s at cycle %0d: got %h want %h", sig_name(mon_e.sel), mon_e.cyc,
                 get_sig(mon_e.sel), mon_e.val);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_at(input int at, input int sel, input logic [15:0] val);
    exp_t e;
    int   pos;
    e.cyc = at; e.sel = sel; e.val = val;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].cyc > at) begin pos = i; break; end
    sb.insert(pos, e);
  endtask

  task automatic send_key(input logic pressed, input logic [8:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int c, r;
    reset_n = 1'b0; tog = 1'b1; ps2_key = 11'h400; joystick = '0;
    rotate = 2'd0; coin_from_start = 1'b0; autofire_en = 2'b00;
    step(3);
    for (int s = 0; s < 5; s++) expect_at(cyc, s, 16'h0);
    checks++;
    if (dir !== 8'h00) begin errors++; $display("FAIL reset dir %h", dir); end
    checks++;
    if (btn !== 8'h00) begin errors++; $display("FAIL reset btn %h", btn); end
    checks++;
    if (start !== 2'b00) begin errors++; $display("FAIL reset start %h", start); end
    checks++;
    if (coin !== 2'b00) begin errors++; $display("FAIL reset coin %h", coin); end
    checks++;
    if (test !== 1'b0) begin errors++; $display("FAIL reset test %h", test); end

    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) expect_at(cyc + i, S_DIR, 16'h0);
    step(3);

    send_key(1'b1, 9'h075);
    expect_at(cyc + 1, S_DIR, 16'h00); expect_at(cyc + 2, S_DIR, 16'h08);
    step(3);
    send_key(1'b0, 9'h075);
    expect_at(cyc + 1, S_DIR, 16'h08); expect_at(cyc + 2, S_DIR, 16'h00);
    step(3);
    send_key(1'b1, 9'h174);
    expect_at(cyc + 2, S_DIR, 16'h01);
    step(3);
    send_key(1'b0, 9'h174);
    expect_at(cyc + 2, S_DIR, 16'h00);
    step(3);
    send_key(1'b1, 9'h01C);
    expect_at(cyc + 2, S_BTN, 16'h10);
    step(3);
    send_key(1'b1, 9'h02C);
    expect_at(cyc + 2, S_TEST, 16'h1); expect_at(cyc + 2, S_BTN, 16'h10);
    step(3);
    send_key(1'b0, 9'h01C);
    expect_at(cyc + 2, S_BTN, 16'h00);
    step(3);
    send_key(1'b0, 9'h02C);
    expect_at(cyc + 2, S_TEST, 16'h0);
    step(3);
    send_key(1'b1, 9'h034);
    expect_at(cyc + 2, S_DIR, 16'h10);
    step(3);
    send_key(1'b0, 9'h034);
    expect_at(cyc + 2, S_DIR, 16'h00);
    step(3);
    send_key(1'b1, 9'h0AA);
    expect_at(cyc + 2, S_DIR, 16'h0); expect_at(cyc + 2, S_BTN, 16'h0);
    expect_at(cyc + 2, S_START, 16'h0); expect_at(cyc + 2, S_TEST, 16'h0);
    step(3);
    send_key(1'b1, 9'h006);
    expect_at(cyc + 2, S_START, 16'h2);
    step(3);
    send_key(1'b0, 9'h006);
    expect_at(cyc + 2, S_START, 16'h0); expect_at(cyc + 2, S_COIN, 16'h0);
    step(3);

    joystick = 32'h0000_0002;
    expect_at(cyc + 1, S_DIR, 16'h02); step(2);
    rotate = 2'd1; expect_at(cyc + 1, S_DIR, 16'h08); step(2);
    checks++;
    if (dir !== 8'h08) begin errors++; $display("FAIL rotate 1 dir %h", dir); end
    rotate = 2'd2; expect_at(cyc + 1, S_DIR, 16'h01); step(2);
    checks++;
    if (dir !== 8'h01) begin errors++; $display("FAIL rotate 2 dir %h", dir); end
    rotate = 2'd3; expect_at(cyc + 1, S_DIR, 16'h04); step(2);
    checks++;
    if (dir !== 8'h04) begin errors++; $display("FAIL rotate 3 dir %h", dir); end
    rotate = 2'd0; joystick = 32'h0000_000C;
    expect_at(cyc + 1, S_DIR, 16'h00); step(2);
    joystick = 32'h0000_000D;
    expect_at(cyc + 1, S_DIR, 16'h01); step(2);
    joystick = '0; step(2);

    c = cyc;
    send_key(1'b1, 9'h02E);
    for (int i = 0; i <= 12; i++) expect_at(c + i, S_COIN, (i >= 2 && i <= 9) ? 16'h1 : 16'h0);
    step(1); send_key(1'b0, 9'h02E);
    step(2); send_key(1'b1, 9'h02E);
    step(2); send_key(1'b0, 9'h02E);
    step(8);
    c = cyc;
    send_key(1'b1, 9'h02E);
    for (int i = 0; i <= 11; i++) expect_at(c + i, S_COIN, (i >= 2 && i <= 9) ? 16'h1 : 16'h0);
    step(1); send_key(1'b0, 9'h02E);
    step(12);

    coin_from_start = 1'b1;
    c = cyc;
    joystick = 32'h0100_0000;
    expect_at(c + 1, S_START, 16'h2);
    for (int i = 0; i <= 10; i++) expect_at(c + i, S_COIN, (i >= 1 && i <= 8) ? 16'h2 : 16'h0);
    step(2); joystick = '0; step(10);
    coin_from_start = 1'b0;
    c = cyc;
    joystick = 32'h0100_0000;
    expect_at(c + 1, S_START, 16'h2);
    for (int i = 0; i <= 10; i++) expect_at(c + i, S_COIN, 16'h0);
    step(2); joystick = '0; step(10);

    c = cyc;
    joystick = 32'h0200_0010;
    send_key(1'b1, 9'h02C);
    expect_at(c + 3, S_BTN, 16'h01); expect_at(c + 3, S_TEST, 16'h1);
    expect_at(c + 3, S_COIN, 16'h2);
    step(4);
    reset_n = 1'b0;
    for (int s = 0; s < 5; s++) expect_at(cyc, s, 16'h0);
    autofire_en = 2'b01;
    joystick = 32'h0000_0010;
    step(2);

    reset_n = 1'b1;
    r = cyc;
    for (int i = 1; i <= 12; i++) expect_at(r + i, S_BTN, (((i - 1) / 4) % 2 == 0) ? 16'h01 : 16'h00);
    expect_at(r + 3, S_TEST, 16'h0);
    step(13);
    autofire_en = 2'b00;
    expect_at(cyc + 1, S_BTN, 16'h01); expect_at(cyc + 2, S_BTN, 16'h01);
    step(3);
    send_key(1'b1, 9'h02C);
    expect_at(cyc + 2, S_TEST, 16'h1);
    step(4);

    @(negedge clk_sys); #1;
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s at cycle %0d: never compared, want %h", sig_name(mon_e.sel), mon_e.cyc, mon_e.val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
